// File: rtl/fp_exception_pipe_pkg.sv
// ============================================================================
// Package     : fpu_exce_pkg
// Description : Shared operation codes, exception codes and sticky-flag bit
//               indices for the FPU operand-exception pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_exce_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } fp_op_e;

  typedef enum logic [2:0] {
    NO_EXCE   = 3'd0,
    QNAN_EXCE = 3'd1,
    INV_EXCE  = 3'd2,
    DZ_EXCE   = 3'd3
  } fp_exce_e;

  localparam int FLAG_QN = 0;
  localparam int FLAG_NV = 1;
  localparam int FLAG_DZ = 2;

  // Maps an exception code onto its {DZ, NV, QN} sticky-flag bit.
  function automatic logic [2:0] exce_flags(input fp_exce_e e);
    logic [2:0] f;
    f = 3'b000;
    case (e)
      QNAN_EXCE: f[FLAG_QN] = 1'b1;
      INV_EXCE:  f[FLAG_NV] = 1'b1;
      DZ_EXCE:   f[FLAG_DZ] = 1'b1;
      default:   f = 3'b000;
    endcase
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_exception_pipe_classify.sv
// ============================================================================
// Module      : fp_classify
// Description : Combinational classifier for one 1+EXP_W+MAN_W operand:
//               NaN, infinity, zero and sign.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_classify #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3
) (
  input  logic [EXP_W+MAN_W:0] op_i,
  output logic                 is_nan_o,
  output logic                 is_inf_o,
  output logic                 is_zero_o,
  output logic                 sign_o
);

  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_man;
  logic             w_exp_ones;
  logic             w_man_zero;

  assign w_exp      = op_i[EXP_W+MAN_W-1:MAN_W];
  assign w_man      = op_i[MAN_W-1:0];
  assign w_exp_ones = &w_exp;
  assign w_man_zero = ~|w_man;

  assign is_nan_o  = w_exp_ones && !w_man_zero;
  assign is_inf_o  = w_exp_ones && w_man_zero;
  assign is_zero_o = (~|w_exp) && w_man_zero;
  assign sign_o    = op_i[EXP_W+MAN_W];

endmodule

`default_nettype wire

// File: rtl/fp_exception_pipe.sv
// ============================================================================
// Module      : fp_exception_pipe
// Description : Registered operand-exception checker with valid/ready stage,
//               IEEE default result, sticky flags and saturating counter.
//               Optional trap output enabled by macro FP_EXCE_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_exception_pipe
  import fpu_exce_pkg::*;
#(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int CNT_W = 8
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [1:0]             FP_OPERATION,
  input  logic [EXP_W+MAN_W:0]   OP_A,
  input  logic [EXP_W+MAN_W:0]   OP_B,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic                   OP_IS_EXCEPTION,
  output logic [2:0]             FP_EXCE,
  output logic [EXP_W+MAN_W:0]   DEFAULT_RES,
  input  logic                   FLAG_CLR,
  output logic [2:0]             STICKY_FLAGS,
`ifdef FP_EXCE_TRAP_EN
  input  logic [2:0]             TRAP_MASK,
  output logic                   TRAP,
`endif
  output logic [CNT_W-1:0]       EXCE_CNT
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [W-1:0]     EXP_ONES = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  localparam logic [W-1:0]     QNAN_RES = EXP_ONES | (W'(1) << (MAN_W - 1));
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic a_nan, a_inf, a_zero, a_sign;
  logic b_nan, b_inf, b_zero, b_sign;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .op_i(OP_A), .is_nan_o(a_nan), .is_inf_o(a_inf), .is_zero_o(a_zero), .sign_o(a_sign)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .op_i(OP_B), .is_nan_o(b_nan), .is_inf_o(b_inf), .is_zero_o(b_zero), .sign_o(b_sign)
  );

  fp_op_e     op;
  fp_exce_e   exce_d, exce_q;
  logic [W-1:0] res_d, res_q;
  logic       out_valid_q;
  logic [2:0] flags_d, flags_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic       accept;
  logic       known_op, invalid, div_zero;

  assign op       = fp_op_e'(FP_OPERATION);
  assign IN_READY = !out_valid_q || OUT_READY;
  assign accept   = IN_VALID && IN_READY;

  // Decode the exception class and its default result; NaN > invalid > divide-by-zero.
  always_comb begin
    known_op = 1'b1;
    invalid  = 1'b0;
    div_zero = 1'b0;
    case (op)
      OP_ADD: invalid = a_inf && b_inf && (a_sign != b_sign);
      OP_SUB: invalid = a_inf && b_inf && (a_sign == b_sign);
      OP_MUL: invalid = (a_zero && b_inf) || (a_inf && b_zero);
      OP_DIV: begin
        invalid  = (a_zero && b_zero) || (a_inf && b_inf);
        div_zero = b_zero;
      end
      default: known_op = 1'b0;
    endcase

    exce_d = NO_EXCE;
    if (known_op) begin
      if (a_nan || b_nan) exce_d = QNAN_EXCE;
      else if (invalid)   exce_d = INV_EXCE;
      else if (div_zero)  exce_d = DZ_EXCE;
    end

    case (exce_d)
      QNAN_EXCE, INV_EXCE: res_d = QNAN_RES;
      DZ_EXCE:             res_d = {a_sign ^ b_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      default:             res_d = '0;
    endcase
  end

  // Sticky flags and event counter: a clear in the same cycle as a new event leaves the event.
  always_comb begin
    flags_d = (FLAG_CLR ? 3'b000 : flags_q) | (accept ? exce_flags(exce_d) : 3'b000);
    cnt_d   = FLAG_CLR ? '0 : cnt_q;
    if (accept && (exce_d != NO_EXCE) && (cnt_d != CNT_MAX)) cnt_d = cnt_d + 1'b1;
  end

  // Result stage: load on accept, hold while stalled, drop valid once drained.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_valid_q <= 1'b0;
      exce_q      <= NO_EXCE;
      res_q       <= '0;
      flags_q     <= 3'b000;
      cnt_q       <= '0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        out_valid_q <= 1'b1;
        exce_q      <= exce_d;
        res_q       <= res_d;
      end else if (OUT_READY) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef FP_EXCE_TRAP_EN
  logic trap_q;

  // Trap pulses in the first cycle a newly loaded result with an enabled class is presented.
  always_ff @(posedge CLK) begin
    if (!RST_N) trap_q <= 1'b0;
    else        trap_q <= accept && |(TRAP_MASK & exce_flags(exce_d));
  end

  assign TRAP = trap_q;
`endif

  assign OUT_VALID       = out_valid_q;
  assign FP_EXCE         = exce_q;
  assign OP_IS_EXCEPTION = (exce_q != NO_EXCE);
  assign DEFAULT_RES     = res_q;
  assign STICKY_FLAGS    = flags_q;
  assign EXCE_CNT        = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_exception_pipe.sv
// ============================================================================
// Module      : tb_fp_exception_pipe
// Description : Self-checking bench for fp_exception_pipe (E4M3 format), with a
//               second instance using a 2-bit counter. Trap checks are built
//               when FP_EXCE_TRAP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_exception_pipe;

  localparam int E = 4;
  localparam int M = 3;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       IN_VALID = 1'b0;
  logic [1:0] FP_OPERATION = 2'd0;
  logic [7:0] OP_A = 8'h00, OP_B = 8'h00;
  logic       OUT_READY = 1'b1;
  logic       FLAG_CLR = 1'b0;
  logic       IN_READY, OUT_VALID, OP_IS_EXCEPTION;
  logic [2:0] FP_EXCE, STICKY_FLAGS;
  logic [7:0] DEFAULT_RES, EXCE_CNT;
  logic       IN_READY2, OUT_VALID2, OP_IS_EXCEPTION2;
  logic [2:0] FP_EXCE2, STICKY_FLAGS2;
  logic [7:0] DEFAULT_RES2;
  logic [1:0] EXCE_CNT2;
`ifdef FP_EXCE_TRAP_EN
  logic [2:0] TRAP_MASK = 3'b000;
  logic       TRAP, TRAP2;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  fp_exception_pipe #(.EXP_W(4), .MAN_W(3), .CNT_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .FP_OPERATION(FP_OPERATION), .OP_A(OP_A), .OP_B(OP_B),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OP_IS_EXCEPTION(OP_IS_EXCEPTION),
    .FP_EXCE(FP_EXCE), .DEFAULT_RES(DEFAULT_RES), .FLAG_CLR(FLAG_CLR),
    .STICKY_FLAGS(STICKY_FLAGS),
`ifdef FP_EXCE_TRAP_EN
    .TRAP_MASK(TRAP_MASK), .TRAP(TRAP),
`endif
    .EXCE_CNT(EXCE_CNT)
  );

  fp_exception_pipe #(.EXP_W(4), .MAN_W(3), .CNT_W(2)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY2),
    .FP_OPERATION(FP_OPERATION), .OP_A(OP_A), .OP_B(OP_B),
    .OUT_VALID(OUT_VALID2), .OUT_READY(OUT_READY), .OP_IS_EXCEPTION(OP_IS_EXCEPTION2),
    .FP_EXCE(FP_EXCE2), .DEFAULT_RES(DEFAULT_RES2), .FLAG_CLR(FLAG_CLR),
    .STICKY_FLAGS(STICKY_FLAGS2),
`ifdef FP_EXCE_TRAP_EN
    .TRAP_MASK(TRAP_MASK), .TRAP(TRAP2),
`endif
    .EXCE_CNT(EXCE_CNT2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference: classify fields arithmetically and apply the exception rules.
  function automatic void ref_op(input int op, input int a, input int b,
                                 output int exce, output int res);
    int ea, ma, eb, mb, sa, sb, emax;
    bit na, ia, za, nb, ib, zb, inv, dz;
    emax = (1 << E) - 1;
    ea = (a >> M) & emax;  ma = a % (1 << M);  sa = (a >> (E + M)) & 1;
    eb = (b >> M) & emax;  mb = b % (1 << M);  sb = (b >> (E + M)) & 1;
    na = (ea == emax) && (ma != 0);  ia = (ea == emax) && (ma == 0);  za = (ea == 0) && (ma == 0);
    nb = (eb == emax) && (mb != 0);  ib = (eb == emax) && (mb == 0);  zb = (eb == 0) && (mb == 0);
    inv = 0; dz = 0;
    if (op == 0) inv = ia && ib && (sa != sb);
    if (op == 1) inv = ia && ib && (sa == sb);
    if (op == 2) inv = (za && ib) || (ia && zb);
    if (op == 3) begin inv = (za && zb) || (ia && ib); dz = zb; end
    if (na || nb)  exce = 1;
    else if (inv)  exce = 2;
    else if (dz)   exce = 3;
    else           exce = 0;
    if (exce == 1 || exce == 2) res = (emax << M) + (1 << (M - 1));
    else if (exce == 3)         res = ((sa ^ sb) << (E + M)) + (emax << M);
    else                        res = 0;
  endfunction

  function automatic int flag_of(input int exce);
    return (exce == 1) ? 1 : (exce == 2) ? 2 : (exce == 3) ? 4 : 0;
  endfunction

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] exce;
    logic [7:0] res;
  } vec_t;

  vec_t vecs[16];
  logic [7:0] specials[9];

  initial begin
    int exp_cnt, exp_flags;
    int mv, me, mr, mf, mc, mc2;
    int e, r;
    bit iv, ordy, clr, acc;

    vecs[0]  = '{2'd0, 8'h78, 8'hF8, 3'd2, 8'h7C};
    vecs[1]  = '{2'd3, 8'h38, 8'h80, 3'd3, 8'hF8};
    vecs[2]  = '{2'd3, 8'h00, 8'h00, 3'd2, 8'h7C};
    vecs[3]  = '{2'd2, 8'h79, 8'h00, 3'd1, 8'h7C};
    vecs[4]  = '{2'd1, 8'h78, 8'hF8, 3'd0, 8'h00};
    vecs[5]  = '{2'd1, 8'h78, 8'h78, 3'd2, 8'h7C};
    vecs[6]  = '{2'd2, 8'hF8, 8'h00, 3'd2, 8'h7C};
    vecs[7]  = '{2'd2, 8'h00, 8'h78, 3'd2, 8'h7C};
    vecs[8]  = '{2'd3, 8'h78, 8'hF8, 3'd2, 8'h7C};
    vecs[9]  = '{2'd3, 8'hF8, 8'h00, 3'd3, 8'hF8};
    vecs[10] = '{2'd0, 8'h38, 8'h40, 3'd0, 8'h00};
    vecs[11] = '{2'd3, 8'h38, 8'h40, 3'd0, 8'h00};
    vecs[12] = '{2'd0, 8'h78, 8'h78, 3'd0, 8'h00};
    vecs[13] = '{2'd3, 8'h00, 8'h38, 3'd0, 8'h00};
    vecs[14] = '{2'd0, 8'h3F, 8'hFF, 3'd1, 8'h7C};
    vecs[15] = '{2'd3, 8'h7F, 8'h00, 3'd1, 8'h7C};
    specials = '{8'h00, 8'h80, 8'h78, 8'hF8, 8'h79, 8'hFF, 8'h38, 8'hB8, 8'h40};

    // Reset state
    RST_N = 1'b0;
    step(); step();
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_is_exce", OP_IS_EXCEPTION, 0);
    check("rst_fp_exce", FP_EXCE, 0);
    check("rst_default_res", DEFAULT_RES, 0);
    check("rst_flags", STICKY_FLAGS, 0);
    check("rst_cnt", EXCE_CNT, 0);
    check("rst_in_ready", IN_READY, 1);
    RST_N = 1'b1;
    step();

    // Directed vector table, one op per cycle
    exp_cnt = 0;
    exp_flags = 0;
    foreach (vecs[i]) begin
      IN_VALID = 1'b1;
      FP_OPERATION = vecs[i].op;
      OP_A = vecs[i].a;
      OP_B = vecs[i].b;
      step();
      IN_VALID = 1'b0;
      if (vecs[i].exce != 0) exp_cnt++;
      exp_flags = exp_flags | flag_of(int'(vecs[i].exce));
      check($sformatf("vec%0d_valid", i), OUT_VALID, 1);
      check($sformatf("vec%0d_exce", i), FP_EXCE, vecs[i].exce);
      check($sformatf("vec%0d_res", i), DEFAULT_RES, vecs[i].res);
      check($sformatf("vec%0d_is_exce", i), OP_IS_EXCEPTION, (vecs[i].exce != 0) ? 1 : 0);
    end
    step();
    check("tbl_out_valid_drop", OUT_VALID, 0);
    check("tbl_flags", STICKY_FLAGS, exp_flags);
    check("tbl_cnt", EXCE_CNT, exp_cnt);
    check("tbl_cnt2_sat", EXCE_CNT2, 3);

    // Clear with a simultaneous DZ op: counter restarts at 1, only DZ set
    FLAG_CLR = 1'b1;
    IN_VALID = 1'b1; FP_OPERATION = 2'd3; OP_A = 8'h38; OP_B = 8'h80;
    step();
    FLAG_CLR = 1'b0; IN_VALID = 1'b0;
    check("clr_set_cnt", EXCE_CNT, 1);
    check("clr_set_cnt2", EXCE_CNT2, 1);
    check("clr_set_flags", STICKY_FLAGS, 3'b100);
    FLAG_CLR = 1'b1;
    step();
    FLAG_CLR = 1'b0;
    check("clr_only_cnt", EXCE_CNT, 0);
    check("clr_only_flags", STICKY_FLAGS, 0);

    // Back-pressure: op1 held for 3 cycles, op2 delivered after release
    RST_N = 1'b0; step(); RST_N = 1'b1;
    OUT_READY = 1'b0;
    IN_VALID = 1'b1; FP_OPERATION = 2'd0; OP_A = 8'h78; OP_B = 8'hF8;
    step();
    FP_OPERATION = 2'd3; OP_A = 8'h38; OP_B = 8'h80;
    for (int k = 0; k < 3; k++) begin
      check("bp_in_ready", IN_READY, 0);
      check("bp_valid", OUT_VALID, 1);
      check("bp_hold_exce", FP_EXCE, 2);
      check("bp_hold_res", DEFAULT_RES, 8'h7C);
      step();
    end
    OUT_READY = 1'b1;
    #1;
    check("bp_release_ready", IN_READY, 1);
    step();
    IN_VALID = 1'b0;
    check("bp_op2_valid", OUT_VALID, 1);
    check("bp_op2_exce", FP_EXCE, 3);
    check("bp_op2_res", DEFAULT_RES, 8'hF8);
    check("bp_cnt", EXCE_CNT, 2);
    step();
    check("bp_drained", OUT_VALID, 0);

    // Reset while a result is stalled discards it and the flags
    OUT_READY = 1'b0;
    IN_VALID = 1'b1; FP_OPERATION = 2'd2; OP_A = 8'h79; OP_B = 8'h00;
    step();
    IN_VALID = 1'b0;
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    OUT_READY = 1'b1;
    check("midrst_valid", OUT_VALID, 0);
    check("midrst_flags", STICKY_FLAGS, 0);
    check("midrst_cnt", EXCE_CNT, 0);
    check("midrst_exce", FP_EXCE, 0);

`ifdef FP_EXCE_TRAP_EN
    // Trap only for enabled DZ class
    TRAP_MASK = 3'b100;
    IN_VALID = 1'b1; FP_OPERATION = 2'd0; OP_A = 8'h78; OP_B = 8'hF8;
    step();
    check("trap_inv", TRAP, 0);
    FP_OPERATION = 2'd3; OP_A = 8'h38; OP_B = 8'h00;
    step();
    IN_VALID = 1'b0;
    check("trap_dz", TRAP, 1);
    step();
    check("trap_pulse_end", TRAP, 0);
    TRAP_MASK = 3'b000;
    RST_N = 1'b0; step(); RST_N = 1'b1;
    check("trap_rst", TRAP, 0);
`endif

    // Randomised traffic against the reference model
    mv = 0; me = 0; mr = 0; mf = 0; mc = 0; mc2 = 0;
    for (int t = 0; t < 400; t++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 19) == 0);
      IN_VALID = iv; OUT_READY = ordy; FLAG_CLR = clr;
      FP_OPERATION = 2'($urandom_range(0, 3));
      OP_A = $urandom_range(0, 1) ? specials[$urandom_range(0, 8)] : 8'($urandom);
      OP_B = $urandom_range(0, 1) ? specials[$urandom_range(0, 8)] : 8'($urandom);
      #1;
      check("rnd_in_ready", IN_READY, (mv == 0 || ordy) ? 1 : 0);
      acc = iv && (mv == 0 || ordy);
      ref_op(int'(FP_OPERATION), int'(OP_A), int'(OP_B), e, r);
      if (clr) begin mf = 0; mc = 0; mc2 = 0; end
      if (acc) begin
        mv = 1; me = e; mr = r;
        mf = mf | flag_of(e);
        if (e != 0 && mc < 255) mc++;
        if (e != 0 && mc2 < 3) mc2++;
      end else if (ordy) begin
        mv = 0;
      end
      step();
      check("rnd_valid", OUT_VALID, mv);
      if (mv != 0) begin
        check("rnd_exce", FP_EXCE, me);
        check("rnd_res", DEFAULT_RES, mr);
        check("rnd_is_exce", OP_IS_EXCEPTION, (me != 0) ? 1 : 0);
      end
      check("rnd_flags", STICKY_FLAGS, mf);
      check("rnd_cnt", EXCE_CNT, mc);
      check("rnd_cnt2", EXCE_CNT2, mc2);
    end
    IN_VALID = 1'b0; FLAG_CLR = 1'b0; OUT_READY = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
